// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the sequential BCD multiplier.
//   state_t        - controller states (IDLE, MULT, CONV, DONE)
//   bcd_digits(n)  - BCD digit count needed for a 2*n-bit magnitude
//   BCD_ADJ_THRESH - double-dabble digit threshold (5)
//   BCD_ADJ        - double-dabble correction added at/above the threshold (3)
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ        = 4'd3;

    // Digits needed to hold the largest 2*n-bit unsigned value in decimal.
    function automatic int bcd_digits(input int n);
        return (2 * n) / 3 + 1;
    endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// bcd_dabble_seq: sequential double-dabble binary-to-BCD converter, one bit
// per clock, P clocks per conversion.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   load   - capture bin and begin a conversion on this edge
//   bin    - P-bit unsigned value to convert
//   bcd    - converted digits, MS digit on top; updates only when a
//            conversion completes, holds otherwise
//   done   - high during the cycle whose rising edge performs the final
//            shift (bcd carries the new result after that edge)
module bcd_dabble_seq
    import mult_pkg::*;
#(
    parameter int P = 16,
    localparam int D = bcd_digits(P / 2)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [P-1:0]   bin,
    output logic [4*D-1:0] bcd,
    output logic           done
);

    localparam int CW = $clog2(P + 1);

    logic [4*D-1:0] work_bcd;
    logic [4*D-1:0] adj_bcd;
    logic [4*D-1:0] shift_bcd;
    logic [P-1:0]   work_bin;
    logic [P-1:0]   shift_bin;
    logic [CW-1:0]  cnt;

    // Adjust every digit >= 5 before the shift so that it carries correctly
    // into the next decade once doubled.
    always_comb begin
        adj_bcd = work_bcd;
        for (int i = 0; i < D; i++) begin
            if (work_bcd[4*i +: 4] >= BCD_ADJ_THRESH) begin
                adj_bcd[4*i +: 4] = work_bcd[4*i +: 4] + BCD_ADJ;
            end
        end
        {shift_bcd, shift_bin} = {adj_bcd[4*D-2:0], work_bin, 1'b0};
    end

    assign done = (cnt == CW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work_bcd <= '0;
            work_bin <= '0;
            cnt      <= '0;
            bcd      <= '0;
        end else if (load) begin
            work_bcd <= '0;
            work_bin <= bin;
            cnt      <= CW'(P);
        end else if (cnt != '0) begin
            work_bcd <= shift_bcd;
            work_bin <= shift_bin;
            cnt      <= cnt - CW'(1);
            if (done) begin
                bcd <= shift_bcd;
            end
        end
    end

endmodule

// File: rtl/seq_mult_bcd.sv
// seq_mult_bcd: N-bit sequential shift-add multiplier with signed/unsigned
// mode and a sequential BCD conversion of |product| for a display driver.
// Optional feature macro: MULT_BCD_EN (defined: CONV state and BCD converter
// present; undefined: bcd tied to 0, MULT goes straight to DONE).
// Ports:
//   clk         - rising-edge clock
//   reset       - asynchronous active-low reset
//   a_in, b_in  - operands, sampled on the start-accept edge
//   signed_mode - 1 = two's complement operands, sampled with the operands
//   start       - level request
//   busy        - operation in progress (MULT/CONV)
//   finish      - result valid (DONE)
//   out         - product, two's complement in signed mode
//   bcd         - BCD digits of |product|, MS digit on top
//   bcd_neg     - signed product is negative
//
// Handshake: start is a level request. In IDLE a rising edge with start=1
// accepts the operands. finish then rises once the result is ready and
// stays high for as long as start is held; dropping start returns the block
// to IDLE and lowers finish. start is ignored while busy.
module seq_mult_bcd
    import mult_pkg::*;
#(
    parameter int N = 8,
    localparam int P = 2 * N,
    localparam int D = bcd_digits(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    input  logic           signed_mode,
    input  logic           start,
    output logic           busy,
    output logic           finish,
    output logic [P-1:0]   out,
    output logic [4*D-1:0] bcd,
    output logic           bcd_neg
);

    localparam int CW = $clog2(P + 1);
    localparam logic [CW-1:0] MULT_LAST = CW'(N - 1);

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  mcand;
    logic [N-1:0]  mag_a;
    logic [N-1:0]  mag_b;
    logic [P-1:0]  acc;
    logic [P-1:0]  acc_next;
    logic [N:0]    acc_add;
    logic          sign;
    logic [CW-1:0] cnt;
    logic          mult_last;

    // Magnitudes: -2^(N-1) negates to itself, which read as unsigned is
    // exactly 2^(N-1), so N bits are enough.
    assign mag_a = (signed_mode && a_in[N-1]) ? -a_in : a_in;
    assign mag_b = (signed_mode && b_in[N-1]) ? -b_in : b_in;

    // Accumulator: upper half is the running partial sum, lower half starts
    // as the multiplier and is consumed LSB first as the sum shifts in.
    assign acc_add   = {1'b0, acc[P-1:N]} + (acc[0] ? {1'b0, mcand} : '0);
    assign acc_next  = {acc_add, acc[N-1:1]};
    assign mult_last = (state == MULT) && (cnt == MULT_LAST);

    function automatic logic [P-1:0] signed_result(input logic [P-1:0] mag,
                                                   input logic neg);
        return (neg && (mag != '0)) ? (~mag + P'(1)) : mag;
    endfunction

`ifdef MULT_BCD_EN
    logic           dabble_done;
    logic [4*D-1:0] dabble_bcd;

    // The converter is loaded with the final product on the last MULT edge
    // so its P shifts line up exactly with the P CONV cycles.
    bcd_dabble_seq #(
        .P (P)
    ) u_dabble (
        .clk   (clk),
        .reset (reset),
        .load  (mult_last),
        .bin   (acc_next),
        .bcd   (dabble_bcd),
        .done  (dabble_done)
    );

    assign bcd = dabble_bcd;
`else
    assign bcd = '0;
`endif

    assign busy   = (state == MULT) || (state == CONV);
    assign finish = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = MULT;
`ifdef MULT_BCD_EN
            MULT: if (cnt == MULT_LAST) state_next = CONV;
            CONV: if (dabble_done) state_next = DONE;
`else
            MULT: if (cnt == MULT_LAST) state_next = DONE;
`endif
            DONE: if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            sign    <= 1'b0;
            cnt     <= '0;
            out     <= '0;
            bcd_neg <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= mag_a;
                        acc   <= {{N{1'b0}}, mag_b};
                        sign  <= signed_mode & (a_in[N-1] ^ b_in[N-1]);
                        cnt   <= '0;
                    end
                end
                MULT: begin
                    acc <= acc_next;
                    if (cnt == MULT_LAST) begin
                        cnt <= '0;
`ifndef MULT_BCD_EN
                        out     <= signed_result(acc_next, sign);
                        bcd_neg <= sign && (acc_next != '0);
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef MULT_BCD_EN
                CONV: begin
                    // acc already holds the final magnitude here.
                    cnt <= cnt + CW'(1);
                    if (dabble_done) begin
                        out     <= signed_result(acc, sign);
                        bcd_neg <= sign && (acc != '0);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
